// File: rtl/llr_frame_loader.sv
// llr_frame_loader: collects a stream of channel LLRs into N = R*D sample
// frames held in two banks. One bank fills while the decoder reads the other
// through the wide sig bus. The most negative input code is clamped so that
// the decoder can negate any stored value without overflow.
//
// state   | meaning
// FILL    | writing accepted samples into bank wsel at index wcnt
// DISCARD | frame overran N samples; dropping input until in_last
module llr_frame_loader #(
  parameter int data_w = 8,
  parameter int R      = 24,
  parameter int D      = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [data_w-1:0]          in_llr,
  input  logic                       in_last,
  output logic [R*D*data_w-1:0]      sig,
  output logic                       sig_valid,
  input  logic                       sig_ack,
  output logic                       err_len,
  output logic [15:0]                frm_cnt
);

  localparam int N  = R * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = N * data_w;

  localparam logic [data_w-1:0] MOST_NEG = {1'b1, {(data_w-1){1'b0}}};
  localparam logic [data_w-1:0] SAT_NEG  = MOST_NEG | data_w'(1);

  typedef enum logic {FILL, DISCARD} state_t;

  state_t            state;
  logic              wsel;
  logic              rsel;
  logic [1:0]        full;
  logic [CW-1:0]     wcnt;
  logic [FW-1:0]     bank0;
  logic [FW-1:0]     bank1;

  logic              accept;
  logic              at_end;
  logic [data_w-1:0] llr_sat;

  // In DISCARD everything is swallowed; in FILL we only stall when the
  // bank we would write still holds an unacknowledged frame.
  assign in_ready  = (state == DISCARD) | ~full[wsel];
  assign accept    = in_valid & in_ready;
  assign at_end    = (wcnt == CW'(N - 1));
  assign llr_sat   = (in_llr == MOST_NEG) ? SAT_NEG : in_llr;
  assign sig_valid = full[rsel];
  assign sig       = rsel ? bank1 : bank0;

  // Sample storage: write the clamped sample into the fill bank at wcnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (accept && (state == FILL)) begin
      for (int k = 0; k < N; k++) begin
        if (wcnt == CW'(k)) begin
          if (wsel) bank1[k*data_w +: data_w] <= llr_sat;
          else      bank0[k*data_w +: data_w] <= llr_sat;
        end
      end
    end
  end

  // Frame control: fill/discard sequencing, bank flags and pointers, error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      wsel    <= 1'b0;
      rsel    <= 1'b0;
      full    <= 2'b00;
      wcnt    <= '0;
      err_len <= 1'b0;
      frm_cnt <= '0;
    end else begin
      err_len <= 1'b0;

      // An ack and a frame completion in the same cycle always touch
      // different banks, so both flag updates can land together.
      if (sig_ack && full[rsel]) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
      end

      if (accept) begin
        case (state)
          FILL: begin
            if (at_end) begin
              full[wsel] <= 1'b1;
              wsel       <= ~wsel;
              wcnt       <= '0;
              frm_cnt    <= frm_cnt + 16'd1;
              if (!in_last) begin
                err_len <= 1'b1;
                state   <= DISCARD;
              end
            end else if (in_last) begin
              // Short frame: leave the bank empty so the next frame overwrites it.
              err_len <= 1'b1;
              wcnt    <= '0;
            end else begin
              wcnt <= wcnt + CW'(1);
            end
          end
          DISCARD: begin
            if (in_last) state <= FILL;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_llr_frame_loader.sv
// Testbench for llr_frame_loader at R=2, D=2 (N=4), data_w=8.
// A frame-level reference model observes the input handshake and queues
// expected frames; a negedge monitor compares DUT outputs against it.
`timescale 1ns/1ps
module tb_llr_frame_loader;

  localparam int DW = 8;
  localparam int R  = 2;
  localparam int D  = 2;
  localparam int N  = R * D;
  localparam int FW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          sig_ack = 1'b0;
  logic [DW-1:0] in_llr = '0;
  logic          in_ready;
  logic          sig_valid;
  logic          err_len;
  logic [FW-1:0] sig;
  logic [15:0]   frm_cnt;

  int errors = 0;
  int checks = 0;
  bit rand_mode = 1'b0;

  llr_frame_loader #(.data_w(DW), .R(R), .D(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_llr   (in_llr),
    .in_last  (in_last),
    .sig      (sig),
    .sig_valid(sig_valid),
    .sig_ack  (sig_ack),
    .err_len  (err_len),
    .frm_cnt  (frm_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'h80) ? 8'h81 : v;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic [7:0]    cur_q[$];
  logic [FW-1:0] exp_q[$];
  bit            discard_m = 1'b0;
  bit            err_m = 1'b0;
  logic [15:0]   frm_m = '0;

  always @(negedge clk) begin
    if (rst) begin
      cur_q.delete();
      exp_q.delete();
      discard_m = 1'b0;
      err_m     = 1'b0;
      frm_m     = '0;
    end else begin
      bit ready_m;
      bit acc;
      ready_m = discard_m || (exp_q.size() < 2);
      chk("in_ready", 64'(in_ready), 64'(ready_m));
      chk("sig_valid", 64'(sig_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("sig", 64'(sig), 64'(exp_q[0]));
      chk("frm_cnt", 64'(frm_cnt), 64'(frm_m));
      chk("err_len", 64'(err_len), 64'(err_m));

      err_m = 1'b0;
      acc = in_valid && ready_m;
      if (sig_ack && (exp_q.size() > 0)) void'(exp_q.pop_front());
      if (acc) begin
        if (discard_m) begin
          if (in_last) discard_m = 1'b0;
        end else begin
          cur_q.push_back(sat(in_llr));
          if (cur_q.size() == N) begin
            logic [FW-1:0] f;
            for (int k = 0; k < N; k++) f[k*DW +: DW] = cur_q[k];
            exp_q.push_back(f);
            frm_m = frm_m + 16'd1;
            cur_q.delete();
            if (!in_last) begin
              err_m     = 1'b1;
              discard_m = 1'b1;
            end
          end else if (in_last) begin
            err_m = 1'b1;
            cur_q.delete();
          end
        end
      end
    end
  end

  // Random acknowledge generator for the randomized phase.
  always @(posedge clk) begin
    #1;
    if (rand_mode) sig_ack = ($urandom_range(0, 2) == 0);
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] v, input logic l);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    in_valid = 1'b1;
    in_llr   = v;
    in_last  = l;
    while (!acc && (t < 200)) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    chk("send_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b1);
  endtask

  task automatic ack_once();
    sig_ack = 1'b1;
    @(posedge clk);
    #1;
    sig_ack = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sig_valid", 64'(sig_valid), 64'd0);
    chk("rst_sig", 64'(sig), 64'd0);
    chk("rst_err_len", 64'(err_len), 64'd0);
    chk("rst_frm_cnt", 64'(frm_cnt), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame
    send4(8'h01, 8'h02, 8'h03, 8'h04);
    chk("basic_valid", 64'(sig_valid), 64'd1);
    chk("basic_sig", 64'(sig), 64'h04030201);
    chk("basic_frm", 64'(frm_cnt), 64'd1);
    ack_once();
    chk("basic_drop", 64'(sig_valid), 64'd0);

    // Saturation
    send4(8'h80, 8'h7F, 8'hFF, 8'h00);
    chk("sat_sig", 64'(sig), 64'h00FF7F81);
    ack_once();

    // Ping-pong backpressure
    send4(8'h11, 8'h12, 8'h13, 8'h14);
    send4(8'h21, 8'h22, 8'h23, 8'h24);
    in_valid = 1'b1;
    in_llr   = 8'h31;
    in_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("pp_hold", 64'(in_ready), 64'd0);
    end
    chk("pp_sig_a", 64'(sig), 64'h14131211);
    @(posedge clk);
    #1;
    sig_ack = 1'b1;
    @(posedge clk);
    #1;
    sig_ack = 1'b0;
    chk("pp_sig_b", 64'(sig), 64'h24232221);
    chk("pp_valid_b", 64'(sig_valid), 64'd1);
    chk("pp_ready", 64'(in_ready), 64'd1);
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    send(8'h33, 1'b0);
    send(8'h34, 1'b1);
    chk("pp_sig_b_hold", 64'(sig), 64'h24232221);
    ack_once();
    chk("pp_sig_c", 64'(sig), 64'h34333231);
    ack_once();
    chk("pp_empty", 64'(sig_valid), 64'd0);

    // Short frame
    send(8'h41, 1'b0);
    send(8'h42, 1'b1);
    chk("short_err", 64'(err_len), 64'd1);
    chk("short_valid", 64'(sig_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("short_err_end", 64'(err_len), 64'd0);
    send4(8'h51, 8'h52, 8'h53, 8'h54);
    chk("short_next_sig", 64'(sig), 64'h54535251);
    ack_once();

    // Long frame
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h64, 1'b0);
    chk("long_err", 64'(err_len), 64'd1);
    chk("long_valid", 64'(sig_valid), 64'd1);
    chk("long_sig", 64'(sig), 64'h64636261);
    chk("long_frm", 64'(frm_cnt), 64'd7);
    send(8'h65, 1'b0);
    send(8'h66, 1'b1);
    send4(8'h71, 8'h72, 8'h73, 8'h74);
    chk("long_sig_hold", 64'(sig), 64'h64636261);
    ack_once();
    chk("long_next_sig", 64'(sig), 64'h74737271);
    ack_once();

    // Reset mid-frame
    send(8'h81, 1'b0);
    send(8'h82, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_sig_valid", 64'(sig_valid), 64'd0);
    chk("mrst_sig", 64'(sig), 64'd0);
    chk("mrst_err_len", 64'(err_len), 64'd0);
    chk("mrst_frm_cnt", 64'(frm_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    send4(8'h91, 8'h92, 8'h93, 8'h94);
    chk("mrst_sig_after", 64'(sig), 64'h94939291);
    chk("mrst_frm_after", 64'(frm_cnt), 64'd1);
    ack_once();

    // Randomized traffic, mostly well-formed frames with some short/long ones
    rand_mode = 1'b1;
    for (int f = 0; f < 80; f++) begin
      int len;
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7)      len = N;
      else if (r < 8) len = int'($urandom_range(1, N - 1));
      else            len = int'($urandom_range(N + 1, N + 3));
      for (int i = 0; i < len; i++) begin
        logic [7:0] v;
        v = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
        send(v, (i == len - 1));
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #2;
    sig_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sig_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_empty", 64'(sig_valid), 64'd0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
